// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep checker: FSM states and the
// golden {and,or,not} truth table, indexed by the vector number {a,b}.
package gate_sweep_pkg;

    localparam int NUM_VEC = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Entry v holds the expected {and, or, not(a)} for {a,b} = v
    localparam logic [2:0] EXPECTED [0:NUM_VEC-1] = '{3'b001, 3'b011, 3'b010, 3'b110};

endpackage

// File: rtl/gate_expect.sv
// Golden model of the AND/OR/NOT gate block: vector index {a,b} to the
// expected {and, or, not} triple.
module gate_expect
    import gate_sweep_pkg::*;
(
    input  logic [1:0] i_vec,
    output logic [2:0] o_expect
);

    assign o_expect = EXPECTED[i_vec];

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives the gate block through all four {a,b} vectors, samples its outputs
// after a programmable settle time and reports pass, error mask and count.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       and_in,
    input  logic       or_in,
    input  logic       not_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [1:0]         r_vec, w_vec_next;
    logic               r_a, w_a_next;
    logic               r_b, w_b_next;
    logic               r_busy, w_busy_next;
    logic               r_done, w_done_next;
    logic               r_pass, w_pass_next;
    logic [3:0]         r_err_mask, w_err_mask_next;
    logic [2:0]         r_err_count, w_err_count_next;
    logic [2:0]         w_expect;

    gate_expect u_expect (
        .i_vec    (r_vec),
        .o_expect (w_expect)
    );

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_vec_next       = r_vec;
        w_a_next         = r_a;
        w_b_next         = r_b;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        w_pass_next      = r_pass;
        w_err_mask_next  = r_err_mask;
        w_err_count_next = r_err_count;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next     = ST_DRIVE;
                    w_cnt_next       = '0;
                    w_vec_next       = 2'd0;
                    w_a_next         = 1'b0;
                    w_b_next         = 1'b0;
                    w_busy_next      = 1'b1;
                    w_pass_next      = 1'b0;
                    w_err_mask_next  = 4'd0;
                    w_err_count_next = 3'd0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_SAMPLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_SAMPLE: begin
                if ({and_in, or_in, not_in} != w_expect) begin
                    w_err_mask_next[r_vec] = 1'b1;
                    w_err_count_next       = r_err_count + 3'd1;
                end
                if (r_vec == 2'd3) begin
                    // Results, done and idle inputs all land on the same edge
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                    w_pass_next  = (w_err_mask_next == 4'd0);
                    w_a_next     = 1'b0;
                    w_b_next     = 1'b0;
                end else begin
                    w_vec_next   = r_vec + 2'd1;
                    {w_a_next, w_b_next} = r_vec + 2'd1;
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DONE: begin
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_vec       <= 2'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_mask  <= 4'd0;
            r_err_count <= 3'd0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_vec       <= w_vec_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_pass      <= w_pass_next;
            r_err_mask  <= w_err_mask_next;
            r_err_count <= w_err_count_next;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_mask  = r_err_mask;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: two checker instances (SETTLE=2 and SETTLE=1) driving a
// behavioural gate block with optional stuck-at faults.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 1: SETTLE=2, gate model with injectable faults
    logic       start, a1, b1, busy1, done1, pass1;
    logic       and1, or1, not1;
    logic [3:0] mask1;
    logic [2:0] cnt1;
    logic       fault_and0 = 1'b0;
    logic       fault_not1 = 1'b0;

    assign and1 = fault_and0 ? 1'b0 : (a1 & b1);
    assign or1  = a1 | b1;
    assign not1 = fault_not1 ? 1'b1 : ~a1;

    gate_sweep_checker #(.SETTLE(2), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a1), .b_out(b1),
        .and_in(and1), .or_in(or1), .not_in(not1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(mask1), .err_count(cnt1)
    );

    // Instance 2: SETTLE=1, fault-free gate model
    logic       start2, a2, b2, busy2, done2, pass2;
    logic [3:0] mask2;
    logic [2:0] cnt2;

    gate_sweep_checker #(.SETTLE(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_out(a2), .b_out(b2),
        .and_in(a2 & b2), .or_in(a2 | b2), .not_in(~a2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_mask(mask2), .err_count(cnt2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start on edge 0, optionally re-pulses it before edge restart_at,
    // and returns the edge number after which done was seen (0 = timeout).
    task automatic run_sweep(input int restart_at, output int edges);
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i == restart_at) start = 1'b1;
            step();
            start = 1'b0;
            if (done1) begin
                edges = i;
                break;
            end
        end
    endtask

    int e;
    int d1, d2;

    initial begin
        start  = 1'b0;
        start2 = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_outputs", {a1, b1, busy1, done1, pass1, mask1, cnt1}, 16'h0);
        check("rst_outputs2", {a2, b2, busy2, done2, pass2, mask2, cnt2}, 16'h0);

        // Clean sweep, vector timing checked edge by edge
        start = 1'b1;
        step();
        start = 1'b0;
        check("accept_busy", {busy1, a1, b1}, 16'b100);
        for (int k = 1; k <= 11; k++) begin
            step();
            check($sformatf("vec_ab_e%0d", k), {done1, a1, b1}, 16'(k / 3));
        end
        step();
        check("clean_done_e12", {done1, busy1, pass1, a1, b1}, 16'b11100);
        check("clean_mask_cnt", {mask1, cnt1}, 16'h0);
        step();
        check("clean_after_e13", {done1, busy1, pass1}, 16'b001);

        // AND stuck at 0: only v3 fails
        fault_and0 = 1'b1;
        run_sweep(-1, e);
        check("and0_latency", 16'(e), 16'd12);
        check("and0_results", {pass1, mask1, cnt1}, {9'd0, 4'b1000, 3'd1});
        fault_and0 = 1'b0;
        step();
        step();
        check("and0_hold_idle", {busy1, pass1, mask1, cnt1}, {8'd0, 1'b0, 4'b1000, 3'd1});

        // NOT stuck at 1: v2 and v3 fail
        fault_not1 = 1'b1;
        run_sweep(-1, e);
        check("not1_results", {pass1, mask1, cnt1}, {9'd0, 4'b1100, 3'd2});
        fault_not1 = 1'b0;
        step();
        step();

        // Start re-pulsed mid-sweep at edge 5 is ignored
        run_sweep(5, e);
        check("restart_latency", 16'(e), 16'd12);
        check("restart_results", {pass1, mask1, cnt1}, {9'd0, 1'b1, 4'b0000, 3'd0});
        step();
        step();

        // Reset during vector 2 (after edge 7) aborts the sweep
        fault_not1 = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 7; k++) step();
        check("pre_rst_vec2", {busy1, a1, b1}, 16'b110);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_outputs", {a1, b1, busy1, done1, pass1, mask1, cnt1}, 16'h0);
        fault_not1 = 1'b0;
        step();
        check("abort_stays_idle", {busy1, done1}, 16'b00);
        run_sweep(-1, e);
        check("post_rst_sweep", {pass1, mask1, cnt1, 8'(e)}, {1'b1, 4'b0000, 3'd0, 8'd12});

        // SETTLE=1 with start held high: done after edge 8, then every 10 edges
        start2 = 1'b1;
        step();
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 9) check("s1_idle_gap", {busy2, done2}, 16'b00);
            if (i == 10) check("s1_relaunch", {busy2, a2, b2}, 16'b100);
            if (done2) begin
                if (d1 == 0) d1 = i;
                else begin
                    d2 = i;
                    break;
                end
            end
        end
        start2 = 1'b0;
        check("s1_first_done", 16'(d1), 16'd8);
        check("s1_done_spacing", 16'(d2 - d1), 16'd10);
        check("s1_results", {pass2, mask2, cnt2}, {1'b1, 4'b0000, 3'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
